// File: rtl/alu_issue_unit.sv
// alu_issue_unit
//   Sequential front end for the combinational MicroUAZ ALU. Accepts one
//   operation at a time, holds the ALU operands in registers for
//   SETTLE_CYCLES cycles, then captures the ALU result and flags and offers
//   them on an output handshake. An 8-bit accumulator tracks the last
//   captured result so operations can be chained (RY taken from acc).
//
//   Ports
//     clk, rst_n           clock, asynchronous active-low reset
//     in_valid/in_ready    request handshake (in_ready only in IDLE)
//     in_op/in_rx/in_ry    ALU select code and operands
//     in_use_acc           source RY from acc instead of in_ry
//     clear_acc            synchronous accumulator clear (capture wins)
//     Sel_ALU/RX/RY        registered ALU inputs
//     R0/Flags             ALU result and flags
//     out_valid/out_ready  result handshake
//     out_result/out_flags captured R0/Flags
//     acc                  accumulator
//     busy                 unit is not IDLE
module alu_issue_unit #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_op,
  input  logic [7:0] in_rx,
  input  logic [7:0] in_ry,
  input  logic       in_use_acc,
  input  logic       clear_acc,
  output logic [3:0] Sel_ALU,
  output logic [7:0] RX,
  output logic [7:0] RY,
  input  logic [7:0] R0,
  input  logic [2:0] Flags,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_result,
  output logic [2:0] out_flags,
  output logic [7:0] acc,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  localparam logic [3:0] LP_CNT_INIT = 4'(SETTLE_CYCLES - 1);

  state_t     r_state;
  state_t     w_next;
  logic       w_accept;
  logic       w_capture;
  logic [3:0] r_cnt;
  logic [3:0] r_sel;
  logic [7:0] r_rx;
  logic [7:0] r_ry;
  logic [7:0] r_res;
  logic [2:0] r_flags;
  logic [7:0] r_acc;

  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_capture = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_accept = 1'b1;
          w_next   = S_DRIVE;
        end
      end
      S_DRIVE: begin
        if (r_cnt == 4'd0) begin
          w_capture = 1'b1;
          w_next    = S_HOLD;
        end
      end
      S_HOLD: begin
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_next;
      if (w_accept)
        r_cnt <= LP_CNT_INIT;
      else if (r_state == S_DRIVE && r_cnt != 4'd0)
        r_cnt <= r_cnt - 4'd1;
    end
  end

  // Operand registers change only on acceptance; RY samples the pre-clear
  // accumulator because acc is updated by the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel <= 4'd0;
      r_rx  <= 8'd0;
      r_ry  <= 8'd0;
    end else if (w_accept) begin
      r_sel <= in_op;
      r_rx  <= in_rx;
      r_ry  <= in_use_acc ? r_acc : in_ry;
    end
  end

  // Capture takes priority over clear_acc on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res   <= 8'd0;
      r_flags <= 3'd0;
      r_acc   <= 8'd0;
    end else begin
      if (w_capture) begin
        r_res   <= R0;
        r_flags <= Flags;
        r_acc   <= R0;
      end else if (clear_acc) begin
        r_acc   <= 8'd0;
      end
    end
  end

  assign in_ready   = (r_state == S_IDLE);
  assign out_valid  = (r_state == S_HOLD);
  assign busy       = (r_state != S_IDLE);
  assign Sel_ALU    = r_sel;
  assign RX         = r_rx;
  assign RY         = r_ry;
  assign out_result = r_res;
  assign out_flags  = r_flags;
  assign acc        = r_acc;

endmodule

// File: doc/alu_issue_unit.md
# alu_issue_unit

Sequential front end for the combinational MicroUAZ ALU. It accepts one operation at a time over a valid/ready handshake and drives the ALU's `RX`, `RY` and `Sel_ALU` inputs from registers. After a programmable settle time it captures `R0` and `Flags` and presents them on an output handshake. It also keeps an 8-bit accumulator so consecutive operations can be chained. It sits between the control unit and the ALU, standing where a testbench driver stands in unit test.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 1: cycles the ALU inputs are held stable before capture. Legal range 1..15.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `in_valid`  in  1  an operation request is present.
- `in_ready`  out  1  unit can accept a request. Equals 1 only in IDLE.
- `in_op`  in  4  ALU select code, passed unchanged to `Sel_ALU`.
- `in_rx`  in  8  operand B.
- `in_ry`  in  8  operand A; ignored when `in_use_acc`=1.
- `in_use_acc`  in  1  drive `RY` from `acc` instead of `in_ry`.
- `clear_acc`  in  1  synchronous clear of `acc`.
- `Sel_ALU`  out  4  to ALU.
- `RX`  out  8  to ALU.
- `RY`  out  8  to ALU.
- `R0`  in  8  ALU result.
- `Flags`  in  3  ALU flags, captured verbatim.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts the result.
- `out_result`  out  8  captured `R0`.
- `out_flags`  out  3  captured `Flags`.
- `acc`  out  8  accumulator; updated with every captured result.
- `busy`  out  1  state is not IDLE.

## Operation
- FSM states: IDLE, DRIVE, HOLD.
- IDLE: `in_ready`=1. At an edge with `in_valid`=1, the unit:
  - registers `Sel_ALU`←`in_op`, `RX`←`in_rx`, and `RY`←(`in_use_acc` ? `acc` : `in_ry`);
  - loads the settle counter with `SETTLE_CYCLES`-1;
  - goes to DRIVE.
- DRIVE: ALU inputs are held constant. The counter decrements each edge. At the edge where the counter is 0, the unit:
  - latches `out_result`←`R0`, `out_flags`←`Flags`, `acc`←`R0`;
  - goes to HOLD.
- HOLD: `out_valid`=1, and `out_result`/`out_flags` are stable. At an edge with `out_ready`=1, the unit goes to IDLE.
- `Sel_ALU`, `RX` and `RY` keep their last values outside DRIVE. They change only on acceptance.
- `clear_acc`:
  - clears `acc` at any edge where no capture occurs;
  - if it coincides with the capture edge, the capture wins and `acc`←`R0`;
  - if it coincides with an acceptance that uses `in_use_acc`, `RY` takes the pre-clear `acc` value.
- `in_valid` while not in IDLE is ignored. No request is queued.
- `out_ready` outside HOLD is ignored.
- The unit performs no width extension or arithmetic. The result is exactly the 8-bit `R0`.

## Timing
- Reset (`rst_n`=0, asynchronous) forces:
  - state=IDLE and counter=0;
  - `Sel_ALU`=0, `RX`=0, `RY`=0;
  - `out_result`=0, `out_flags`=0, `acc`=0;
  - `out_valid`=0, `busy`=0, `in_ready`=1.
- Deassertion takes effect at the next rising edge.
- Reset mid-operation abandons the operation. No `out_valid` is produced for it.
- Latency: acceptance at edge E0; capture at edge E0+`SETTLE_CYCLES`; `out_valid` high from that edge.
- Minimum issue interval: `SETTLE_CYCLES`+2 cycles, reached with `out_ready` held at 1. The unit is back in IDLE one cycle after `out_valid` rises and can accept again at the following edge.
- `in_ready`, `out_valid` and `busy` are decoded from registered state only. There is no combinational path from inputs to outputs.

## Test plan
The bench uses an ALU stub:
- 0000 = RY+RX; 0001 = RY−RX (mod 256).
- `Flags[0]` = carry/borrow, `Flags[1]` = zero, `Flags[2]` = bit 7 of the result.

Scenarios:
- Reset with `SETTLE_CYCLES`=1, then drive op 0001, RY=4, RX=4 → `out_valid` high 1 cycle after acceptance; `out_result`=0, `out_flags`=3'b010, `acc`=0.
- Op 0000, RY=255, RX=1 → `out_result`=0, `out_flags`=3'b011. Hold `out_ready`=0 for 5 cycles → `out_valid` and the data stay stable, and `in_ready` stays 0 even though `in_valid` is held.
- Chaining: op 0000, RY=2, RX=1, then op 0000 with `in_use_acc`=1, RX=10 → second `RY`=3, `out_result`=13, `acc`=13.
- Assert `clear_acc` on the capture edge of op 0001, RY=10, RX=5 → `acc`=5. Assert `clear_acc` one cycle later → `acc`=0, and `out_result` stays 5.
- `SETTLE_CYCLES`=4: change the stub result after 2 cycles of DRIVE → `RX`/`RY`/`Sel_ALU` are constant for 4 cycles, and the captured value is the one present at edge E0+4.
- Assert `rst_n` low during DRIVE → all outputs take their reset values immediately, no `out_valid` appears, and the next request completes normally.
